// File: rtl/pwm_ramp_ctrl_if.sv
// Requester handshakes and PWM command outputs of pwm_ramp_ctrl.
// master = requesters/PWM side, slave = the controller.
interface pwm_ramp_ctrl_if;
  logic       req0_valid;
  logic [7:0] req0_code;
  logic       req0_ack;
  logic       req1_valid;
  logic [7:0] req1_code;
  logic       req1_ack;
  logic [7:0] duty_code;
  logic [3:0] level;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output req0_valid, req0_code, req1_valid, req1_code,
    input  req0_ack, req1_ack, duty_code, level, busy, done, err
  );

  modport slave (
    input  req0_valid, req0_code, req1_valid, req1_code,
    output req0_ack, req1_ack, duty_code, level, busy, done, err
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Round-robin arbiter for two ASCII duty requests, ramping the PWM duty code
// one 10 % level per STEP_TICKS cycles toward the accepted target.
module pwm_ramp_ctrl #(
  parameter int STEP_TICKS = 5_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_ramp_ctrl_if.slave  bus
);
  localparam int CW = $clog2(STEP_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEP_TICKS - 1);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t          state, state_n;
  logic            rr, rr_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      lvl, lvl_n, tgt, tgt_n, lvl_step;
  logic [1:0]      ack, ack_n;
  logic            busy_q, busy_n, done_q, done_n, err_q, err_n;
  logic [7:0]      duty_q;
  logic [1:0]      valid;
  logic [1:0][7:0] code;
  logic            gnt;
  logic [7:0]      gcode;

  assign valid = {bus.req1_valid, bus.req0_valid};
  assign code  = {bus.req1_code, bus.req0_code};

  always_comb begin
    state_n  = state;
    rr_n     = rr;
    cnt_n    = cnt;
    lvl_n    = lvl;
    tgt_n    = tgt;
    ack_n    = '0;
    busy_n   = busy_q;
    done_n   = 1'b0;
    err_n    = 1'b0;
    gnt      = 1'b0;
    gcode    = 8'h00;
    lvl_step = lvl;
    case (state)
      IDLE: begin
        // a still-high ack means that requester has not dropped valid yet
        if ((|valid) && !(|ack)) begin
          gnt        = (&valid) ? rr : valid[1];
          rr_n       = ~gnt;
          ack_n[gnt] = 1'b1;
          gcode      = code[gnt];
          if (gcode < 8'h30 || gcode > 8'h39) begin
            err_n = 1'b1;
          end else if (gcode[3:0] == lvl) begin
            done_n = 1'b1;
          end else begin
            state_n = RAMP;
            busy_n  = 1'b1;
            cnt_n   = '0;
            tgt_n   = gcode[3:0];
          end
        end
      end
      RAMP: begin
        if (cnt == LAST) begin
          cnt_n    = '0;
          lvl_step = (tgt > lvl) ? lvl + 4'd1 : lvl - 4'd1;
          lvl_n    = lvl_step;
          if (lvl_step == tgt) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr     <= 1'b0;
      cnt    <= '0;
      lvl    <= 4'd0;
      tgt    <= 4'd0;
      ack    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      duty_q <= 8'h30;
    end else begin
      state  <= state_n;
      rr     <= rr_n;
      cnt    <= cnt_n;
      lvl    <= lvl_n;
      tgt    <= tgt_n;
      ack    <= ack_n;
      busy_q <= busy_n;
      done_q <= done_n;
      err_q  <= err_n;
      duty_q <= {4'h3, lvl_n};
    end
  end

  assign bus.req0_ack  = ack[0];
  assign bus.req1_ack  = ack[1];
  assign bus.duty_code = duty_q;
  assign bus.level     = lvl;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Randomised bench for pwm_ramp_ctrl: an arithmetic ramp model predicts
// acks, err/done pulses, busy and level/duty every cycle.
module tb_pwm_ramp_ctrl;
  localparam int ST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pwm_ramp_ctrl_if bus ();

  pwm_ramp_ctrl #(.STEP_TICKS(ST)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;

  // model: a ramp is start level, direction and cycles elapsed since acceptance
  int m_level, m_tgt, m_l0, m_dir, m_k, m_rr;
  bit m_ramp, m_ackprev;
  bit e_ack0, e_ack1, e_busy, e_done, e_err;

  task automatic model_reset();
    m_level = 0; m_tgt = 0; m_l0 = 0; m_dir = 0; m_k = 0; m_rr = 0;
    m_ramp = 0; m_ackprev = 0;
    e_ack0 = 0; e_ack1 = 0; e_busy = 0; e_done = 0; e_err = 0;
  endtask

  task automatic model_edge();
    int g, c;
    e_ack0 = 0; e_ack1 = 0; e_done = 0; e_err = 0;
    if (m_ramp) begin
      m_k++;
      m_level = m_l0 + m_dir * (m_k / ST);
      if (m_level == m_tgt) begin
        e_done = 1; m_ramp = 0;
      end
    end else if (!m_ackprev && (bus.req0_valid || bus.req1_valid)) begin
      if (bus.req0_valid && bus.req1_valid) g = m_rr;
      else g = bus.req1_valid ? 1 : 0;
      m_rr = 1 - g;
      if (g == 0) begin e_ack0 = 1; c = int'(bus.req0_code); end
      else        begin e_ack1 = 1; c = int'(bus.req1_code); end
      if (c < 'h30 || c > 'h39) e_err = 1;
      else if (c - 'h30 == m_level) e_done = 1;
      else begin
        m_ramp = 1; m_tgt = c - 'h30; m_l0 = m_level; m_k = 0;
        m_dir = (m_tgt > m_level) ? 1 : -1;
      end
    end
    e_busy = m_ramp;
    m_ackprev = e_ack0 | e_ack1;
  endtask

  function automatic logic [16:0] obs();
    return {bus.req0_ack, bus.req1_ack, bus.busy, bus.done, bus.err, bus.level, bus.duty_code};
  endfunction

  function automatic logic [16:0] expv();
    logic [3:0] l;
    l = 4'(m_level);
    return {e_ack0, e_ack1, e_busy, e_done, e_err, l, {4'h3, l}};
  endfunction

  // one clock: model follows the edge, requesters drop valid once acked
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    model_edge();
    if (bus.req0_ack) bus.req0_valid = 1'b0;
    if (bus.req1_ack) bus.req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_code = 8'h30; bus.req1_code = 8'h30;
    model_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++; $display("FAIL reset: got %h want %h", obs(), expv());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ramp_up();
    bus.req0_code = 8'h35; bus.req0_valid = 1'b1;
    repeat (24) begin
      cycle();
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL ramp_up cyc %0d: got %h want %h", cyc, obs(), expv());
      end
    end
    n_chk++;
    if (bus.duty_code !== 8'h35) begin
      n_fail++; $display("FAIL ramp_up_final: got %h want 35", bus.duty_code);
    end
  endtask

  task automatic test_ramp_down();
    bus.req1_code = 8'h32; bus.req1_valid = 1'b1;
    repeat (16) begin
      cycle();
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL ramp_down cyc %0d: got %h want %h", cyc, obs(), expv());
      end
    end
    n_chk++;
    if (bus.duty_code !== 8'h32) begin
      n_fail++; $display("FAIL ramp_down_final: got %h want 32", bus.duty_code);
    end
  endtask

  task automatic test_contention();
    bus.req0_code = 8'h37; bus.req0_valid = 1'b1;
    bus.req1_code = 8'h33; bus.req1_valid = 1'b1;
    repeat (45) begin
      cycle();
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL contention cyc %0d: got %h want %h", cyc, obs(), expv());
      end
    end
    n_chk++;
    if (bus.duty_code !== 8'h33) begin
      n_fail++; $display("FAIL contention_final: got %h want 33", bus.duty_code);
    end
  endtask

  task automatic test_err_equal();
    bus.req1_code = 8'h41; bus.req1_valid = 1'b1;
    repeat (3) begin
      cycle();
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL err cyc %0d: got %h want %h", cyc, obs(), expv());
      end
    end
    bus.req0_code = 8'(8'h30 + m_level); bus.req0_valid = 1'b1;
    repeat (3) begin
      cycle();
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL equal cyc %0d: got %h want %h", cyc, obs(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    bus.req0_code = 8'h30; bus.req0_valid = 1'b1;
    while ((m_level != 3 || !m_ramp || m_tgt != 8) && guard < 80) begin
      if (!m_ramp && !bus.req0_valid && m_level != 3) begin
        bus.req0_code = 8'h38; bus.req0_valid = 1'b1;
      end
      cycle();
      guard++;
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL pre_reset cyc %0d: got %h want %h", cyc, obs(), expv());
      end
    end
    if (guard >= 80) begin
      n_chk++; n_fail++; $display("FAIL reset_mid_timeout: got %0d cycles want <80", guard);
    end
    rst_n = 1'b0;
    bus.req0_code = 8'h34; bus.req0_valid = 1'b1;
    #1;
    model_reset();
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++; $display("FAIL reset_mid: got %h want %h", obs(), expv());
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      cycle();
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL after_reset cyc %0d: got %h want %h", cyc, obs(), expv());
      end
    end
  endtask

  function automatic logic [7:0] rand_code();
    if ($urandom_range(0, 5) == 0) return 8'($urandom_range(0, 255));
    return 8'(8'h30 + $urandom_range(0, 9));
  endfunction

  task automatic test_random();
    int guard = 0;
    repeat (600) begin
      if (!bus.req0_valid && $urandom_range(0, 7) == 0) begin
        bus.req0_code = rand_code(); bus.req0_valid = 1'b1;
      end
      if (!bus.req1_valid && $urandom_range(0, 7) == 0) begin
        bus.req1_code = rand_code(); bus.req1_valid = 1'b1;
      end
      cycle();
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h want %h", cyc, obs(), expv());
      end
    end
    while ((m_ramp || bus.req0_valid || bus.req1_valid) && guard < 200) begin
      cycle();
      guard++;
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL drain cyc %0d: got %h want %h", cyc, obs(), expv());
      end
    end
    if (guard >= 200) begin
      n_chk++; n_fail++; $display("FAIL drain_timeout: got %0d cycles want <200", guard);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_contention();
    test_err_equal();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
